// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button conditioner: channel index constants
// (bit positions on btn_raw / btn_level / btn_press / btn_rel), the default
// channel count, the default auto-repeat eligibility mask and the per-channel
// debounce state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package button_pkg;

  localparam int BTN_MOVE_L   = 0;
  localparam int BTN_MOVE_R   = 1;
  localparam int BTN_AIM_L    = 2;
  localparam int BTN_AIM_R    = 3;
  localparam int BTN_SHOOT    = 4;
  localparam int BTN_NEW_GAME = 5;

  localparam int NUM_BTN_DEF = 6;

  // Only the move and aim channels (bits 0..3) may auto-repeat.
  localparam logic [NUM_BTN_DEF-1:0] REPEAT_MASK_DEF = 6'b001111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-FF synchroniser, debounce FSM with a saturating
// stability counter, and (when AUTO_REPEAT_EN is defined) an auto-repeat
// counter that re-fires the press pulse while the button stays held.
// Build option: AUTO_REPEAT_EN (undefined = no repeat engine, one press pulse
// per accepted press).
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   raw    in   raw asynchronous button pin
//   level  out  debounced level, 1 = held
//   press  out  one-cycle pulse on accepted press or repeat tick
//   rel    out  one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module btn_debounce_ch
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16,
  parameter bit RPT_EN          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic          sync1_p0;
  logic          sync2_p1;
  btn_state_e    state_q;
  btn_state_e    state_d;
  logic [CW-1:0] cnt_q;
  logic          press_d;
  logic          rel_d;
  logic          level_d;
  logic          rpt_tick;

  // ---- stage p0/p1: synchroniser; sync2 is the only view of the pin downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_p0 <= 1'b0;
      sync2_p1 <= 1'b0;
    end else begin
      sync1_p0 <= raw;
      sync2_p1 <= sync1_p0;
    end
  end

  // ---- debounce FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- debounce FSM: next state
  // The IDLE->PRESS_CHK (or HELD->REL_CHK) sample does not count; the
  // checking state needs DEBOUNCE_CYCLES further agreeing samples.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (sync2_p1) state_d = PRESS_CHK;
      PRESS_CHK: begin
        if (!sync2_p1)             state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = HELD;
      end
      HELD:      if (!sync2_p1) state_d = REL_CHK;
      REL_CHK: begin
        if (sync2_p1)               state_d = HELD;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // ---- debounce FSM: outputs (registered below)
  // level follows HELD and REL_CHK alike so a release under test never dips.
  always_comb begin
    press_d = (state_q == PRESS_CHK) && (state_d == HELD);
    rel_d   = (state_q == REL_CHK)   && (state_d == IDLE);
    level_d = (state_d == HELD) || (state_d == REL_CHK);
  end

  // Stability counter: restarts on every state change, saturates otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt_q;
  logic          rpt_first_q;

  // First tick waits REPEAT_DELAY after the press pulse, later ones REPEAT_PERIOD.
  assign rpt_tick = RPT_EN && (state_q == HELD) &&
                    (rpt_cnt_q == (rpt_first_q ? DLY_LAST : PER_LAST));

  // Cleared in IDLE/PRESS_CHK so it starts at the press pulse; frozen in REL_CHK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (!RPT_EN || (state_q == IDLE) || (state_q == PRESS_CHK)) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (state_q == HELD) begin
      if (rpt_tick) begin
        rpt_cnt_q   <= '0;
        rpt_first_q <= 1'b0;
      end else begin
        rpt_cnt_q <= rpt_cnt_q + RW'(1);
      end
    end
  end
`else
  // Repeat engine compiled out; the repeat parameters stay on the interface
  // so both builds instantiate identically.
  assign rpt_tick = 1'b0 & (RPT_EN | (REPEAT_DELAY > 0) | (REPEAT_PERIOD > 0));
`endif

  // ---- output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      level <= level_d;
      press <= press_d | rpt_tick;
      rel   <= rel_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions the six raw push-button pins (move L/R, aim L/R, shoot, new game)
// into clk-synchronous debounced levels and one-cycle press/release pulses
// for the controls block. Channels are fully independent.
// Build option: AUTO_REPEAT_EN enables auto-repeat on REPEAT_MASK channels.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   btn_raw    in   [NUM_BTN] raw pins, bit order per button_pkg constants
//   btn_level  out  [NUM_BTN] debounced level, 1 = held
//   btn_press  out  [NUM_BTN] one-cycle press / repeat pulse
//   btn_rel    out  [NUM_BTN] one-cycle release pulse
// -----------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int                 NUM_BTN         = NUM_BTN_DEF,
  parameter int                 DEBOUNCE_CYCLES = 16,
  parameter int                 REPEAT_DELAY    = 64,
  parameter int                 REPEAT_PERIOD   = 16,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(REPEAT_MASK_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_rel
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .RPT_EN          (REPEAT_MASK[i])
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_rel[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=4). Expected output events are queued with their due cycle
// as stimulus is applied; a negedge monitor pops and compares them, and on
// every other cycle requires silent pulses and the last expected level.
// Inputs driven 1 time unit after a rising edge are first sampled on the
// next edge, so an accepted change appears 3+DEBOUNCE_CYCLES cycles later.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int DB  = 4;
  localparam int LAT = 3 + DB;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] btn_raw;
  logic [5:0] btn_level;
  logic [5:0] btn_press;
  logic [5:0] btn_rel;

  typedef struct {
    int         cyc;
    logic [5:0] press;
    logic [5:0] rel;
    logic [5:0] level;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         chk_en = 1'b0;
  logic [5:0] exp_level = 6'h00;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .btn_rel   (btn_rel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Monitor: compare against the scoreboard on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (sb.size() > 0) begin
        n_cmp++;
        assert (sb[0].cyc >= cyc) else begin
          n_bad++;
          $error("FAIL %s overdue: now cycle %0d, due cycle %0d", sb[0].tag, cyc, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        exp_level = e.level;
        n_cmp++;
        assert (btn_press === e.press) else begin
          n_bad++;
          $error("FAIL %s press: got %h expected %h", e.tag, btn_press, e.press);
        end
        n_cmp++;
        assert (btn_rel === e.rel) else begin
          n_bad++;
          $error("FAIL %s rel: got %h expected %h", e.tag, btn_rel, e.rel);
        end
        n_cmp++;
        assert (btn_level === e.level) else begin
          n_bad++;
          $error("FAIL %s level: got %h expected %h", e.tag, btn_level, e.level);
        end
      end else begin
        n_cmp++;
        assert ((btn_press === 6'h00) && (btn_rel === 6'h00)) else begin
          n_bad++;
          $error("FAIL quiet_c%0d pulses: got press=%h rel=%h expected 00/00", cyc, btn_press, btn_rel);
        end
        n_cmp++;
        assert (btn_level === exp_level) else begin
          n_bad++;
          $error("FAIL quiet_c%0d level: got %h expected %h", cyc, btn_level, exp_level);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 200 && cyc < c; i++) step();
  endtask

  task automatic push(input int c, input logic [5:0] p, input logic [5:0] r,
                      input logic [5:0] l, input string tag);
    exp_t x;
    x.cyc = c; x.press = p; x.rel = r; x.level = l; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) step();
    repeat (4) step();
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL %s drain: %0d events pending, expected 0", tag, sb.size());
    end
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    assert ({btn_press, btn_rel, btn_level} === 18'h0) else begin
      n_bad++;
      $error("FAIL %s outputs: got press=%h rel=%h level=%h expected all 0",
             tag, btn_press, btn_rel, btn_level);
    end
  endtask

  initial begin
    int s;
    int t;
    // 1. reset held with all buttons down, then release
    reset   = 1'b0;
    btn_raw = 6'h3F;
    #1;
    check_zero("rst_t0");
    repeat (5) begin
      step();
      check_zero("rst_hold");
    end
    reset     = 1'b1;
    exp_level = 6'h00;
    chk_en    = 1'b1;
    s = cyc;
    push(s + LAT, 6'h3F, 6'h00, 6'h3F, "t1_press");
    wait_until(s + LAT);
    btn_raw = 6'h00;
    push(cyc + LAT, 6'h00, 6'h3F, 6'h00, "t1_rel");
    drain("t1");

    // 2. short glitch on shoot: no activity expected
    btn_raw = 6'h10;
    repeat (3) step();
    btn_raw = 6'h00;
    repeat (15) step();
    drain("t2");

    // 3. bouncing shoot then steady press and steady release
    btn_raw = 6'h10; step();
    btn_raw = 6'h00; step();
    btn_raw = 6'h10; step();
    btn_raw = 6'h00; step();
    btn_raw = 6'h10;
    s = cyc;
    push(s + LAT, 6'h10, 6'h00, 6'h10, "t3_press");
    wait_until(s + 10);
    btn_raw = 6'h00;
    push(cyc + LAT, 6'h00, 6'h10, 6'h00, "t3_rel");
    drain("t3");

    // 4. move_left and shoot held 30 cycles; only move_left may repeat
    btn_raw = 6'h11;
    s = cyc;
    push(s + LAT, 6'h11, 6'h00, 6'h11, "t4_press");
`ifdef AUTO_REPEAT_EN
    push(s + LAT + 8,  6'h01, 6'h00, 6'h11, "t4_rpt8");
    push(s + LAT + 12, 6'h01, 6'h00, 6'h11, "t4_rpt12");
    push(s + LAT + 16, 6'h01, 6'h00, 6'h11, "t4_rpt16");
    push(s + LAT + 20, 6'h01, 6'h00, 6'h11, "t4_rpt20");
    push(s + LAT + 24, 6'h01, 6'h00, 6'h11, "t4_rpt24");
`endif
    wait_until(s + 30);
    btn_raw = 6'h00;
    push(cyc + LAT, 6'h00, 6'h11, 6'h00, "t4_rel");
    drain("t4");

    // 5. simultaneous move_left + move_right
    btn_raw = 6'h03;
    s = cyc;
    push(s + LAT, 6'h03, 6'h00, 6'h03, "t5_press");
    wait_until(s + LAT + 1);
    btn_raw = 6'h00;
    push(cyc + LAT, 6'h00, 6'h03, 6'h00, "t5_rel");
    drain("t5");

    // 6. reset while aim_left is held, button still held after release
    btn_raw = 6'h04;
    s = cyc;
    push(s + LAT, 6'h04, 6'h00, 6'h04, "t6_press");
    wait_until(s + LAT + 2);
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_zero("t6_rst_async");
    repeat (3) begin
      step();
      check_zero("t6_rst_hold");
    end
    reset     = 1'b1;
    exp_level = 6'h00;
    chk_en    = 1'b1;
    t = cyc;
    push(t + LAT, 6'h04, 6'h00, 6'h04, "t6_repress");
    wait_until(t + LAT + 1);
    btn_raw = 6'h00;
    push(cyc + LAT, 6'h00, 6'h04, 6'h00, "t6_rel");
    drain("t6");

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
